// File: rtl/sm83_bus_responder.sv
// Converts SM83 fetch/execute cycle strobes into single req/ack memory transactions.
// Define SM83_BUS_TIMEOUT_EN to abandon unacknowledged accesses after TIMEOUT_CYCLES (open bus 0xFF).
module sm83_bus_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_cycle,
    input  logic        execute_cycle,
    input  logic [15:0] pc,
    input  logic [15:0] addr,
    input  logic        wr_en,
    input  logic [7:0]  wdata,
    output logic [7:0]  opcode,
    output logic [7:0]  rdata,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic        fetch;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } slot_t;

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_q, state_d;
    slot_t       act_q, act_d;
    slot_t       pend_q, pend_d;
    logic        pend_valid_q, pend_valid_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    slot_t       fetch_slot, exec_slot;

`ifdef SM83_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign fetch_slot = '{fetch: 1'b1, we: 1'b0, addr: pc, wdata: wdata};
    assign exec_slot  = '{fetch: 1'b0, we: wr_en, addr: addr, wdata: wdata};

    always_comb begin
        state_d      = state_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        opcode_d     = opcode_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
`ifdef SM83_BUS_TIMEOUT_EN
        cnt_d        = '0;
`endif

        // Strobe capture: idle goes straight to the active slot, otherwise one-deep pending.
        if (state_q == S_IDLE && !pend_valid_q) begin
            if (fetch_cycle) begin
                act_d   = fetch_slot;
                state_d = S_ISSUE;
                if (execute_cycle) begin
                    pend_d       = exec_slot;
                    pend_valid_d = 1'b1;
                end
            end else if (execute_cycle) begin
                act_d   = exec_slot;
                state_d = S_ISSUE;
            end
        end else if (fetch_cycle || execute_cycle) begin
            if (pend_valid_q) begin
                err_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_d       = fetch_cycle ? fetch_slot : exec_slot;
            end
            if (fetch_cycle && execute_cycle) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pend_valid_q) begin
                    act_d        = pend_q;
                    pend_valid_d = 1'b0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                    if (act_q.fetch) begin
                        opcode_d = mem_rdata;
                    end else if (!act_q.we) begin
                        rdata_d = mem_rdata;
                    end
                end
`ifdef SM83_BUS_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    if (act_q.fetch) begin
                        opcode_d = 8'hFF;
                    end else if (!act_q.we) begin
                        rdata_d = 8'hFF;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                // A strobe captured in this same cycle is forwarded without an IDLE bubble.
                if (pend_valid_d) begin
                    act_d        = pend_d;
                    pend_valid_d = 1'b0;
                    state_d      = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            act_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            opcode_q     <= 8'h00;
            rdata_q      <= 8'h00;
            err_q        <= 1'b0;
`ifdef SM83_BUS_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            opcode_q     <= opcode_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
`ifdef SM83_BUS_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign mem_req   = (state_q == S_ISSUE);
    assign mem_we    = mem_req & act_q.we;
    assign mem_addr  = act_q.addr;
    assign mem_wdata = act_q.wdata;
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE) || pend_valid_q;
    assign err       = err_q;
    assign opcode    = opcode_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_sm83_bus_responder.sv
// Self-checking bench for sm83_bus_responder: directed vector table, hand sequences,
// and randomized strobes checked against a queue-based transaction model.
module tb_sm83_bus_responder;

    localparam int unsigned TO_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_cycle, execute_cycle, wr_en, mem_ack;
    logic [15:0] pc, addr;
    logic [7:0]  wdata, mem_rdata;
    logic [7:0]  opcode, rdata;
    logic        done, busy, err, mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;

    always #5 clk = ~clk;

    sm83_bus_responder #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_cycle  (fetch_cycle),
        .execute_cycle(execute_cycle),
        .pc           (pc),
        .addr         (addr),
        .wr_en        (wr_en),
        .wdata        (wdata),
        .opcode       (opcode),
        .rdata        (rdata),
        .done         (done),
        .busy         (busy),
        .err          (err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    typedef struct packed {
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic        dn;
        logic        bsy;
        logic        er;
        logic [7:0]  op;
        logic [7:0]  rd;
    } obs_t;

    typedef struct {
        logic        f;
        logic        e;
        logic [15:0] p;
        logic [15:0] a;
        logic        w;
        logic [7:0]  d;
        logic        ack;
        logic [7:0]  mrd;
        obs_t        exp;
    } vec_t;

    typedef struct {
        logic        fetch;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vt[$];

    // reference model state
    txn_t        q[$];
    logic [7:0]  mem_img [int];
    bit          serving, done_now, pre_serving, m_err;
    int          wait_left, cap;
    logic [7:0]  m_op, m_rd;
    txn_t        h;
    logic        sf, se, swe;
    logic [15:0] spc, sad;
    logic [7:0]  swd;
    obs_t        got, expv;

    function automatic obs_t mk(input logic rq, input logic w, input logic [15:0] a,
                                input logic [7:0] d, input logic dn, input logic b,
                                input logic e, input logic [7:0] o, input logic [7:0] r);
        obs_t x;
        x.req = rq; x.we = w; x.addr = a; x.wd = d; x.dn = dn;
        x.bsy = b; x.er = e; x.op = o; x.rd = r;
        return x;
    endfunction

    function automatic obs_t observe();
        return mk(mem_req, mem_we, mem_addr, mem_wdata, done, busy, err, opcode, rdata);
    endfunction

    function automatic string fmt(input obs_t x);
        return $sformatf("req=%0b we=%0b addr=%04h wd=%02h done=%0b busy=%0b err=%0b op=%02h rd=%02h",
                         x.req, x.we, x.addr, x.wd, x.dn, x.bsy, x.er, x.op, x.rd);
    endfunction

    task automatic check(input string name, input obs_t g, input obs_t x);
        n_cmp++;
        if (g !== x) begin
            n_bad++;
            $display("FAIL %s: got %s, expected %s", name, fmt(g), fmt(x));
        end
    endtask

    function automatic logic [7:0] rd_mem(input logic [15:0] a);
        if (mem_img.exists(int'(a))) return mem_img[int'(a)];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic void add_vec(input logic f, input logic e, input logic [15:0] p,
                                    input logic [15:0] a, input logic w, input logic [7:0] d,
                                    input logic ack, input logic [7:0] mrd, input obs_t x);
        vec_t v;
        v.f = f; v.e = e; v.p = p; v.a = a; v.w = w; v.d = d;
        v.ack = ack; v.mrd = mrd; v.exp = x;
        vt.push_back(v);
    endfunction

    task automatic drive(input logic f, input logic e, input logic [15:0] p, input logic [15:0] a,
                         input logic w, input logic [7:0] d, input logic ack, input logic [7:0] mrd);
        fetch_cycle = f; execute_cycle = e; pc = p; addr = a;
        wr_en = w; wdata = d; mem_ack = ack; mem_rdata = mrd;
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge.
    task automatic step(input logic rn, input logic f, input logic e, input logic [15:0] p,
                        input logic [15:0] a, input logic w, input logic [7:0] d,
                        input logic ack, input logic [7:0] mrd, input string name, input obs_t x);
        @(negedge clk);
        rst_n = rn;
        drive(f, e, p, a, w, d, ack, mrd);
        @(posedge clk);
        #1;
        check(name, observe(), x);
    endtask

    task automatic idle_step(input string name, input obs_t x);
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 8'h00, 1'b0, 8'h00, name, x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 8'h00, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 8'h00, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("reset_values", observe(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // fetch at 0x0100, ack 0x31 in first ISSUE cycle
        add_vec(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, mk(1'b1, 1'b0, 16'h0100, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00));
        add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b1, 8'h31, mk(1'b0, 1'b0, 16'h0100, 8'h00, 1'b1, 1'b1, 1'b0, 8'h31, 8'h00));
        add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, mk(1'b0, 1'b0, 16'h0100, 8'h00, 1'b0, 1'b0, 1'b0, 8'h31, 8'h00));
        // write 0xA5 to 0xC000, three wait cycles
        add_vec(1'b0, 1'b1, 16'h0000, 16'hC000, 1'b1, 8'hA5, 1'b0, 8'h00, mk(1'b1, 1'b1, 16'hC000, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h31, 8'h00));
        for (int i = 0; i < 3; i++)
            add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, mk(1'b1, 1'b1, 16'hC000, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h31, 8'h00));
        add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b1, 8'h77, mk(1'b0, 1'b0, 16'hC000, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h31, 8'h00));
        add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, mk(1'b0, 1'b0, 16'hC000, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h31, 8'h00));
        // simultaneous fetch 0x0150 and read 0xFF44; stray ack during DONE is ignored
        add_vec(1'b1, 1'b1, 16'h0150, 16'hFF44, 1'b0, 8'h00, 1'b0, 8'h00, mk(1'b1, 1'b0, 16'h0150, 8'h00, 1'b0, 1'b1, 1'b0, 8'h31, 8'h00));
        add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b1, 8'hC3, mk(1'b0, 1'b0, 16'h0150, 8'h00, 1'b1, 1'b1, 1'b0, 8'hC3, 8'h00));
        add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b1, 8'hDD, mk(1'b1, 1'b0, 16'hFF44, 8'h00, 1'b0, 1'b1, 1'b0, 8'hC3, 8'h00));
        add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b1, 8'h90, mk(1'b0, 1'b0, 16'hFF44, 8'h00, 1'b1, 1'b1, 1'b0, 8'hC3, 8'h90));
        add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, mk(1'b0, 1'b0, 16'hFF44, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC3, 8'h90));
        // read in flight, second strobe pending, third dropped
        add_vec(1'b0, 1'b1, 16'h0000, 16'h8000, 1'b0, 8'h00, 1'b0, 8'h00, mk(1'b1, 1'b0, 16'h8000, 8'h00, 1'b0, 1'b1, 1'b0, 8'hC3, 8'h90));
        add_vec(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, mk(1'b1, 1'b0, 16'h8000, 8'h00, 1'b0, 1'b1, 1'b0, 8'hC3, 8'h90));
        add_vec(1'b0, 1'b1, 16'h0000, 16'h9000, 1'b1, 8'h11, 1'b0, 8'h00, mk(1'b1, 1'b0, 16'h8000, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC3, 8'h90));
        add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b1, 8'h42, mk(1'b0, 1'b0, 16'h8000, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC3, 8'h42));
        add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, mk(1'b1, 1'b0, 16'h0200, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC3, 8'h42));
        add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b1, 8'h3E, mk(1'b0, 1'b0, 16'h0200, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3E, 8'h42));
        add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, mk(1'b0, 1'b0, 16'h0200, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3E, 8'h42));
        add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b1, 8'hEE, mk(1'b0, 1'b0, 16'h0200, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3E, 8'h42));

        for (int i = 0; i < vt.size(); i++) begin
            step(1'b1, vt[i].f, vt[i].e, vt[i].p, vt[i].a, vt[i].w, vt[i].d, vt[i].ack, vt[i].mrd,
                 $sformatf("vec%0d", i), vt[i].exp);
            $display("vec %0d: fetch=%0b exec=%0b ack=%0b -> %s", i, vt[i].f, vt[i].e, vt[i].ack, fmt(observe()));
        end

        // reset while an access is in flight with a pending strobe
        step(1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, "rst_seq_fetch",
             mk(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3E, 8'h42));
        step(1'b1, 1'b0, 1'b1, 16'h0000, 16'h2222, 1'b1, 8'h66, 1'b0, 8'h00, "rst_seq_pend",
             mk(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3E, 8'h42));
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b1, 8'h55, "rst_mid_access", '0);
        idle_step("rst_after1", '0);
        idle_step("rst_after2", '0);
        $display("reset-mid-access sequence complete");

        // access that is never acknowledged
        step(1'b1, 1'b1, 1'b0, 16'h0300, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, "noack_start",
             mk(1'b1, 1'b0, 16'h0300, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00));
`ifdef SM83_BUS_TIMEOUT_EN
        for (int k = 1; k < TO_CYCLES; k++)
            idle_step($sformatf("timeout_wait%0d", k), mk(1'b1, 1'b0, 16'h0300, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00));
        idle_step("timeout_done", mk(1'b0, 1'b0, 16'h0300, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00));
        idle_step("timeout_idle", mk(1'b0, 1'b0, 16'h0300, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00));
`else
        for (int k = 1; k < 40; k++)
            idle_step($sformatf("noack_hold%0d", k), mk(1'b1, 1'b0, 16'h0300, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00));
`endif
        $display("unacknowledged-access sequence complete");
        do_reset();

        // randomized strobes against the transaction-queue model
        serving = 1'b0; done_now = 1'b0; m_err = 1'b0; m_op = 8'h00; m_rd = 8'h00;
        wait_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            sf  = ($urandom_range(0, 99) < 25);
            se  = ($urandom_range(0, 99) < 25);
            spc = 16'($urandom);
            sad = 16'($urandom);
            swe = 1'($urandom_range(0, 1));
            swd = 8'($urandom);
            drive(sf, se, spc, sad, swe, swd, 1'b0, 8'($urandom));
            if (serving && wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_mem(q[0].addr);
            end else begin
                mem_ack = !serving && ($urandom_range(0, 7) == 0);
            end
            @(posedge clk);
            pre_serving = serving;
            cap = 2 - q.size() - (done_now ? 1 : 0);
            done_now = 1'b0;
            if (pre_serving) begin
                if (wait_left == 0) begin
                    h = q.pop_front();
                    if (h.fetch) m_op = rd_mem(h.addr);
                    else if (!h.we) m_rd = rd_mem(h.addr);
                    else mem_img[int'(h.addr)] = h.wdata;
                    serving  = 1'b0;
                    done_now = 1'b1;
                end else begin
                    wait_left--;
                end
            end
            if (sf) begin
                if (cap > 0) begin
                    h.fetch = 1'b1; h.we = 1'b0; h.addr = spc; h.wdata = swd;
                    q.push_back(h);
                    cap--;
                end else m_err = 1'b1;
            end
            if (se) begin
                if (cap > 0) begin
                    h.fetch = 1'b0; h.we = swe; h.addr = sad; h.wdata = swd;
                    q.push_back(h);
                    cap--;
                end else m_err = 1'b1;
            end
            if (!pre_serving && q.size() > 0) begin
                serving   = 1'b1;
                wait_left = int'($urandom_range(0, 4));
            end
            #1;
            expv = mk(1'b0, 1'b0, 16'h0, 8'h00, done_now, serving || done_now || (q.size() != 0), m_err, m_op, m_rd);
            if (serving) begin
                expv.req  = 1'b1;
                expv.we   = q[0].we;
                expv.addr = q[0].addr;
                expv.wd   = q[0].wdata;
            end
            got = observe();
            if (!serving) begin
                got.addr = 16'h0;
                got.wd   = 8'h00;
            end
            check($sformatf("rand_cyc%0d", cyc), got, expv);
        end
        $display("random phase complete");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
